gorf_sample_fetch: RTL and testbench



---
 rtl/gorf_sample_fetch_if.sv | 28 ++
 rtl/gorf_sample_fetch.sv | 135 +++++++++++++
 tb/tb_gorf_sample_fetch.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/gorf_sample_fetch_if.sv
// Sample-player / DDRAM-arbiter signal bundle for the Gorf sample fetch stage.
// The slave modport is the fetch stage; the master modport is the environment
// around it (sample player request side plus DDRAM arbiter port).
interface gorf_sample_fetch_if;
  // Sample player side
  logic        s_enable;
  logic [23:0] s_addr;
  logic        s_read;
  logic [15:0] s_data;
  logic        s_ready;
  // DDRAM arbiter side
  logic        ddr_busy;
  logic        ddr_rd;
  logic [28:0] ddr_addr;
  logic [7:0]  ddr_burstcnt;
  logic [63:0] ddr_dout;
  logic        ddr_dout_ready;

  modport slave (
    input  s_enable, s_addr, s_read, ddr_busy, ddr_dout, ddr_dout_ready,
    output s_data, s_ready, ddr_rd, ddr_addr, ddr_burstcnt
  );

  modport master (
    output s_enable, s_addr, s_read, ddr_busy, ddr_dout, ddr_dout_ready,
    input  s_data, s_ready, ddr_rd, ddr_addr, ddr_burstcnt
  );
endinterface

// File: rtl/gorf_sample_fetch.sv
// Gorf sample fetch: serves 16-bit sample reads from DDRAM through a one-line
// cache holding a single 64-bit word (four samples). One DDRAM read in flight
// at most; a request arriving while busy is parked in a one-deep pending slot.
module gorf_sample_fetch #(
  parameter logic [28:0] BASE_WADDR = 29'h0600_0000,
  parameter int          HIT_ENABLE = 1
) (
  input logic                 CLK,
  input logic                 I_RESET_L,
  gorf_sample_fetch_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic        s_read_d;
  logic        req, start, hit, discard, latch_req;
  logic        pend_q, valid_q, drop_q;
  logic [23:1] pend_addr, sel_addr;
  logic [20:0] sel_word, tag_q, cur_word;
  logic [1:0]  sel_lane, cur_lane;
  logic [63:0] line_q;
  logic [15:0] s_data_q;
  logic        s_ready_q, ddr_rd_q;
  logic [28:0] ddr_addr_q;
  logic        addr_bit0_unused;

  // Byte address bit 0 carries no information for 16-bit samples.
  assign addr_bit0_unused = bus.s_addr[0];

  // A request is the rising edge of s_read while samples are loaded.
  assign req       = bus.s_read & ~s_read_d & bus.s_enable;
  // Requests that cannot start right now go to the pending slot; this includes
  // a fresh edge in the same IDLE cycle that drains an older pending request.
  assign latch_req = req & ((state_q != IDLE) | pend_q);
  assign start     = (state_q == IDLE) & bus.s_enable & (pend_q | req);
  assign sel_addr  = pend_q ? pend_addr : bus.s_addr[23:1];
  assign sel_word  = sel_addr[23:3];
  assign sel_lane  = sel_addr[2:1];
  assign hit       = (HIT_ENABLE != 0) && valid_q && (tag_q == sel_word);
  // An in-flight read whose s_enable dropped finishes on the bus but is thrown away.
  assign discard   = drop_q | ~bus.s_enable;

  // State register.
  always_ff @(posedge CLK) begin
    if (!I_RESET_L) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assigned first so every path drives state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = hit ? RESP : ISSUE;
      ISSUE:   if (!bus.ddr_busy) state_d = WAIT;
      WAIT:    if (bus.ddr_dout_ready) state_d = discard ? IDLE : RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control registers and registered outputs.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, whatever order the statements appear in.
    if (!I_RESET_L) begin
      s_read_d   <= 1'b0;
      pend_q     <= 1'b0;
      valid_q    <= 1'b0;
      drop_q     <= 1'b0;
      s_ready_q  <= 1'b0;
      s_data_q   <= '0;
      ddr_rd_q   <= 1'b0;
      ddr_addr_q <= '0;
    end else begin
      s_read_d  <= bus.s_read;
      s_ready_q <= 1'b0;

      if (!bus.s_enable) pend_q <= 1'b0;
      else if (latch_req) pend_q <= 1'b1;
      else if (start)     pend_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (start) begin
            drop_q <= 1'b0;
            if (!hit) begin
              ddr_rd_q   <= 1'b1;
              ddr_addr_q <= BASE_WADDR + {8'b0, sel_word};
            end
          end
        end
        ISSUE: if (!bus.ddr_busy) ddr_rd_q <= 1'b0;
        WAIT:  if (bus.ddr_dout_ready && !discard) valid_q <= 1'b1;
        RESP: begin
          if (!discard) begin
            s_ready_q <= 1'b1;
            s_data_q  <= line_q[16*cur_lane +: 16];
          end
        end
        default: ;
      endcase

      // Disabling invalidates the line and marks any in-flight read for discard;
      // placed last so it overrides a fill in the same cycle.
      if (!bus.s_enable) begin
        valid_q <= 1'b0;
        if (state_q != IDLE) drop_q <= 1'b1;
      end
    end
  end

  // Datapath registers: line, tag and request addresses.
  always_ff @(posedge CLK) begin
    // NOTE: these are qualified by valid_q/pend_q/state, so they carry no reset
    // and never feed an output before being written.
    if (latch_req) pend_addr <= bus.s_addr[23:1];
    if (start) begin
      cur_word <= sel_word;
      cur_lane <= sel_lane;
    end
    if (state_q == WAIT && bus.ddr_dout_ready && !discard) begin
      line_q <= bus.ddr_dout;
      tag_q  <= cur_word;
    end
  end

  assign bus.s_data       = s_data_q;
  assign bus.s_ready      = s_ready_q;
  assign bus.ddr_rd       = ddr_rd_q;
  assign bus.ddr_addr     = ddr_addr_q;
  assign bus.ddr_burstcnt = 8'd1;

endmodule

// File: tb/tb_gorf_sample_fetch.sv
// Self-checking bench for gorf_sample_fetch: a table of sequential sample reads
// against a small DDRAM responder, then hand-written multi-cycle sequences.
module tb_gorf_sample_fetch;
  localparam logic [28:0] BASE = 29'h0600_0000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  gorf_sample_fetch_if bus ();

  gorf_sample_fetch #(.BASE_WADDR(BASE), .HIT_ENABLE(1)) dut (
    .CLK       (clk),
    .I_RESET_L (rst_n),
    .bus       (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // DDRAM contents seen by the responder.
  function automatic logic [63:0] mem_word(input logic [28:0] w);
    logic [11:0] o;
    o = w[11:0];
    if (w == BASE) return 64'h4444_3333_2222_1111;
    return {4'hD, o, 4'hC, o, 4'hB, o, 4'hA, o};
  endfunction

  // Bus monitor: event counters and cycle stamps taken at the active edge.
  int          cyc = 0, cmd_cnt = 0, rdy_cnt = 0, drdy_cnt = 0;
  int          req_cyc = 0, rd_rise_cyc = 0, drdy_cyc = 0, srdy_cyc = 0;
  logic [28:0] cmd_addr = '0;
  logic        prev_read = 1'b0, prev_rd = 1'b0;

  always @(posedge clk) begin
    if (bus.s_read && !prev_read && bus.s_enable) req_cyc = cyc;
    if (bus.ddr_rd && !prev_rd) rd_rise_cyc = cyc;
    if (bus.ddr_rd && !bus.ddr_busy) begin
      cmd_cnt++;
      cmd_addr = bus.ddr_addr;
    end
    if (bus.ddr_dout_ready) begin
      drdy_cnt++;
      drdy_cyc = cyc;
    end
    if (bus.s_ready) begin
      rdy_cnt++;
      srdy_cyc = cyc;
    end
    prev_read = bus.s_read;
    prev_rd   = bus.ddr_rd;
    cyc++;
  end

  // DDRAM responder: returns the word resp_delay cycles after each accepted command.
  int          resp_delay = 2;
  int          seen_cmd = 0;
  int          timer = 0;
  logic [28:0] raddr = '0;
  logic        resp_rdy = 1'b0;
  logic        stray_rdy = 1'b0;
  logic [63:0] dout_v = '0;

  assign bus.ddr_dout_ready = resp_rdy | stray_rdy;
  assign bus.ddr_dout       = dout_v;

  always @(negedge clk) begin
    resp_rdy = 1'b0;
    if (cmd_cnt != seen_cmd) begin
      seen_cmd = cmd_cnt;
      timer    = resp_delay;
      raddr    = cmd_addr;
    end else if (timer > 0) begin
      timer--;
      if (timer == 0) begin
        resp_rdy = 1'b1;
        dout_v   = mem_word(raddr);
      end
    end
  end

  task automatic pulse_read(input logic [23:0] a);
    bus.s_addr = a;
    bus.s_read = 1'b1;
    @(negedge clk);
    bus.s_read = 1'b0;
  endtask

  task automatic wait_rdy(input int target, input string name);
    int n = 0;
    while (rdy_cnt < target && n < 60) begin
      @(negedge clk);
      n++;
    end
    check(name, rdy_cnt, target);
  endtask

  task automatic wait_cmd(input int target, input string name);
    int n = 0;
    while (cmd_cnt < target && n < 60) begin
      @(negedge clk);
      n++;
    end
    check(name, cmd_cnt, target);
  endtask

  typedef struct {
    logic [23:0] addr;
    logic        miss;
    logic [28:0] waddr;
    logic [15:0] data;
  } vec_t;

  vec_t vecs[12];
  int   c0, r0, d0, n;

  initial begin
    vecs[0]  = '{24'h000004, 1'b1, 29'h0600_0000, 16'h3333};
    vecs[1]  = '{24'h000006, 1'b0, 29'h0600_0000, 16'h4444};
    vecs[2]  = '{24'h000000, 1'b0, 29'h0600_0000, 16'h1111};
    vecs[3]  = '{24'h000002, 1'b0, 29'h0600_0000, 16'h2222};
    vecs[4]  = '{24'h000008, 1'b1, 29'h0600_0001, 16'hA001};
    vecs[5]  = '{24'h00000E, 1'b0, 29'h0600_0001, 16'hD001};
    vecs[6]  = '{24'h00000C, 1'b0, 29'h0600_0001, 16'hC001};
    vecs[7]  = '{24'h000004, 1'b1, 29'h0600_0000, 16'h3333};
    vecs[8]  = '{24'h000123, 1'b1, 29'h0600_0024, 16'hB024};
    vecs[9]  = '{24'h000122, 1'b0, 29'h0600_0024, 16'hB024};
    vecs[10] = '{24'hFFFFFE, 1'b1, 29'h061F_FFFF, 16'hDFFF};
    vecs[11] = '{24'hFFFFF8, 1'b0, 29'h061F_FFFF, 16'hAFFF};

    rst_n        = 1'b0;
    bus.s_enable = 1'b1;
    bus.s_addr   = '0;
    bus.s_read   = 1'b0;
    bus.ddr_busy = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst s_data", bus.s_data, 16'h0);
    check("rst s_ready", bus.s_ready, 1'b0);
    check("rst ddr_rd", bus.ddr_rd, 1'b0);
    check("rst ddr_addr", bus.ddr_addr, 29'h0);
    check("burstcnt", bus.ddr_burstcnt, 8'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Table: sequential reads, hit/miss, lane select, address wrap.
    for (int i = 0; i < 12; i++) begin
      c0 = cmd_cnt;
      r0 = rdy_cnt;
      pulse_read(vecs[i].addr);
      wait_rdy(r0 + 1, $sformatf("vec%0d ready", i));
      check($sformatf("vec%0d data", i), bus.s_data, vecs[i].data);
      check($sformatf("vec%0d cmds", i), cmd_cnt - c0, {31'b0, vecs[i].miss});
      if (vecs[i].miss) begin
        check($sformatf("vec%0d ddr_addr", i), cmd_addr, vecs[i].waddr);
        check($sformatf("vec%0d rd lat", i), rd_rise_cyc - req_cyc, 1);
        check($sformatf("vec%0d miss lat", i), srdy_cyc - drdy_cyc, 2);
      end else begin
        check($sformatf("vec%0d hit lat", i), srdy_cyc - req_cyc, 2);
      end
      @(negedge clk);
    end

    // Busy stall during ISSUE.
    c0 = cmd_cnt;
    r0 = rdy_cnt;
    bus.ddr_busy = 1'b1;
    pulse_read(24'h000040);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("stall rd %0d", k), bus.ddr_rd, 1'b1);
      check($sformatf("stall addr %0d", k), bus.ddr_addr, 29'h0600_0008);
      @(negedge clk);
    end
    bus.ddr_busy = 1'b0;
    wait_rdy(r0 + 1, "stall ready");
    check("stall data", bus.s_data, 16'hA008);
    repeat (10) @(negedge clk);
    check("stall cmds", cmd_cnt - c0, 1);
    check("stall pulses", rdy_cnt - r0, 1);

    // Two edges during WAIT: latest pending address wins.
    resp_delay = 8;
    c0 = cmd_cnt;
    r0 = rdy_cnt;
    pulse_read(24'h000080);
    wait_cmd(c0 + 1, "pend first cmd");
    pulse_read(24'h000010);
    @(negedge clk);
    pulse_read(24'h000020);
    wait_rdy(r0 + 1, "pend ready1");
    check("pend data1", bus.s_data, 16'hA010);
    wait_rdy(r0 + 2, "pend ready2");
    check("pend data2", bus.s_data, 16'hA004);
    check("pend ddr_addr", cmd_addr, 29'h0600_0004);
    repeat (20) @(negedge clk);
    check("pend cmds", cmd_cnt - c0, 2);
    check("pend pulses", rdy_cnt - r0, 2);

    // s_enable drop during WAIT: data discarded, line stays invalid.
    resp_delay = 6;
    c0 = cmd_cnt;
    r0 = rdy_cnt;
    pulse_read(24'h000100);
    wait_cmd(c0 + 1, "dis cmd");
    bus.s_enable = 1'b0;
    d0 = drdy_cnt;
    n  = 0;
    while (drdy_cnt == d0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("dis dout seen", drdy_cnt - d0, 1);
    repeat (5) @(negedge clk);
    check("dis no ready", rdy_cnt - r0, 0);
    bus.s_enable = 1'b1;
    @(negedge clk);
    pulse_read(24'h000100);
    wait_rdy(r0 + 1, "dis reissue ready");
    check("dis reissue cmds", cmd_cnt - c0, 2);
    check("dis reissue addr", cmd_addr, 29'h0600_0020);
    check("dis reissue data", bus.s_data, 16'hA020);
    @(negedge clk);

    // Reset mid-read during ISSUE, then a stray dout_ready.
    resp_delay = 2;
    c0 = cmd_cnt;
    r0 = rdy_cnt;
    bus.ddr_busy = 1'b1;
    pulse_read(24'h000200);
    check("mid rd before", bus.ddr_rd, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid rst ddr_rd", bus.ddr_rd, 1'b0);
    check("mid rst s_ready", bus.s_ready, 1'b0);
    check("mid rst s_data", bus.s_data, 16'h0);
    check("mid rst ddr_addr", bus.ddr_addr, 29'h0);
    rst_n = 1'b1;
    bus.ddr_busy = 1'b0;
    repeat (3) @(negedge clk);
    stray_rdy = 1'b1;
    @(negedge clk);
    stray_rdy = 1'b0;
    repeat (5) @(negedge clk);
    check("mid stray ready", rdy_cnt - r0, 0);
    check("mid stray cmds", cmd_cnt - c0, 0);
    check("mid idle rd", bus.ddr_rd, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
